// File: rtl/root_node_rr_aggregator.sv
// Round-robin merge of NUM_CHILD buffered child channels into one registered, source-tagged stream.
// Head word reaches the output two edges after an empty-FIFO push; a full channel deasserts in_ready.
module root_node_rr_aggregator #(
  parameter int NUM_CHILD = 5,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  localparam int SRC_W    = (NUM_CHILD > 2) ? $clog2(NUM_CHILD) : 1,
  localparam int LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CHILD-1:0]        in_valid,
  output logic [NUM_CHILD-1:0]        in_ready,
  input  logic [NUM_CHILD*DATA_W-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [SRC_W-1:0]            out_src,
  output logic [NUM_CHILD*LVL_W-1:0]  lvl
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [DATA_W-1:0] mem_q    [NUM_CHILD][DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_CHILD];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_CHILD];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_CHILD];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_CHILD];
  logic [LVL_W-1:0]  lvl_q    [NUM_CHILD];
  logic [LVL_W-1:0]  lvl_d    [NUM_CHILD];

  logic [NUM_CHILD-1:0] push, pop, nonempty;
  logic [SRC_W-1:0]     last_q, last_d, grant;
  logic                 found, load;
  int                   idx;

  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic [SRC_W-1:0]     out_src_q, out_src_d;

  always_comb begin
    in_ready = '0;
    nonempty = '0;
    push     = '0;
    lvl      = '0;
    for (int i = 0; i < NUM_CHILD; i++) begin
      in_ready[i]               = rst_n && (lvl_q[i] != FULL_LVL);
      nonempty[i]               = (lvl_q[i] != '0);
      push[i]                   = in_valid[i] && in_ready[i];
      lvl[i*LVL_W +: LVL_W]     = lvl_q[i];
    end
  end

  // Scan starts just past the last winner, so the channel served last ranks lowest.
  always_comb begin
    grant = last_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_CHILD; k++) begin
      idx = (int'(last_q) + k) % NUM_CHILD;
      if (!found && nonempty[idx]) begin
        grant = SRC_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign load = (!out_valid_q || out_ready) && (|nonempty);

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CHILD; i++) begin
      pop[i]      = load && (grant == SRC_W'(i));
      rd_ptr_d[i] = pop[i]  ? rd_ptr_q[i] + PTR_W'(1) : rd_ptr_q[i];
      wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + PTR_W'(1) : wr_ptr_q[i];
      lvl_d[i]    = lvl_q[i];
      if (push[i] && !pop[i]) begin
        lvl_d[i] = lvl_q[i] + LVL_W'(1);
      end else if (!push[i] && pop[i]) begin
        lvl_d[i] = lvl_q[i] - LVL_W'(1);
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    last_d      = last_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[grant][rd_ptr_q[grant]];
      out_src_d   = grant;
      last_d      = grant;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHILD; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        lvl_q[i]    <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      last_q      <= SRC_W'(NUM_CHILD - 1);
    end else begin
      for (int i = 0; i < NUM_CHILD; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        lvl_q[i]    <= lvl_d[i];
      end
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      last_q      <= last_d;
    end
  end

  // Storage needs no reset: contents are only read behind a non-zero level.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHILD; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_root_node_rr_aggregator.sv
// Directed bench for root_node_rr_aggregator: reset, latency, round-robin, full/wrap,
// random stall with scoreboard and starvation bound, and reset mid-stream.
module tb_root_node_rr_aggregator;
  localparam int NC = 5;
  localparam int DW = 8;
  localparam int DP = 4;
  localparam int SW = 3;
  localparam int LW = 3;

  logic             clk;
  logic             rst_n;
  logic [NC-1:0]    in_valid;
  logic [NC-1:0]    in_ready;
  logic [NC*DW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [SW-1:0]    out_src;
  logic [NC*LW-1:0] lvl;

  int vectors = 0;
  int miscompares = 0;

  logic [11:0]   sbq[$];
  int            st[NC];
  logic [LW-1:0] pl[NC];
  logic          pv, pr;
  logic [DW-1:0] pd;
  logic [SW-1:0] ps;

  root_node_rr_aggregator #(.NUM_CHILD(NC), .DATA_W(DW), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .lvl       (lvl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] lv(input int i);
    return lvl[i*LW +: LW];
  endfunction

  // Match the word about to transfer against the oldest queued word of its channel.
  task automatic sb_pop;
    int f;
    f = -1;
    for (int q = 0; q < sbq.size(); q++)
      if (f < 0 && sbq[q][11:8] == {1'b0, out_src}) f = q;
    chk("sb_order", 32'({1'b0, out_src, out_data}), 32'((f >= 0) ? sbq[f] : 12'hfff));
    if (f >= 0) sbq.delete(f);
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    in_valid = 5'($urandom);
    in_data = 40'({$urandom, $urandom});
    out_ready = 1'($urandom);
    #1;
    chk("rst_in_ready_low", 32'(in_ready), 32'h0);
    tick;
    in_valid = 5'($urandom);
    tick;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_src", 32'(out_src), 32'h0);
    chk("rst_lvl", 32'(lvl), 32'h0);
    chk("rst_in_ready_hold", 32'(in_ready), 32'h0);
    in_valid = '0;
    out_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'h1f);

    // single word latency
    in_data = '0;
    in_data[3*8 +: 8] = 8'hA5;
    in_valid = 5'b01000;
    tick;
    in_valid = '0;
    chk("lat_lvl3_push", 32'(lv(3)), 32'd1);
    chk("lat_valid_E", 32'(out_valid), 32'h0);
    tick;
    chk("lat_word", 32'({out_valid, out_src, out_data}), 32'({1'b1, 3'd3, 8'hA5}));
    chk("lat_lvl3_pop", 32'(lv(3)), 32'd0);
    tick;
    chk("lat_xfer_idle", 32'(out_valid), 32'h0);

    // round-robin order
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    out_ready = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NC; i++) in_data[i*8 +: 8] = {4'(i), 4'(p)};
      in_valid = 5'h1f;
      tick;
    end
    in_valid = '0;
    chk("rr_lvl0", 32'(lv(0)), 32'd1);
    chk("rr_lvl4", 32'(lv(4)), 32'd2);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("rr_word", 32'({out_valid, out_src, 4'(k % 5), 4'(k / 5)}) , 32'({1'b1, 3'(k % 5), out_data}));
      chk("rr_src", 32'(out_src), 32'(k % 5));
      tick;
    end
    chk("rr_end_idle", 32'(out_valid), 32'h0);

    // full, backpressure and wrap on channel 1
    out_ready = 1'b0;
    in_data[7:0] = 8'h0E;
    in_valid = 5'b00001;
    tick;
    in_valid = '0;
    tick;
    chk("full_park", 32'({out_valid, out_src, out_data}), 32'({1'b1, 3'd0, 8'h0E}));
    for (int j = 1; j <= 6; j++) begin
      in_data[15:8] = 8'(j);
      in_valid = 5'b00010;
      chk("full_in_ready", 32'(in_ready[1]), 32'(j <= 4));
      tick;
    end
    in_valid = '0;
    chk("full_lvl1", 32'(lv(1)), 32'd4);
    chk("full_ready_low", 32'(in_ready[1]), 32'h0);
    chk("full_out_hold", 32'({out_valid, out_src, out_data}), 32'({1'b1, 3'd0, 8'h0E}));
    out_ready = 1'b1;
    tick;
    chk("wrap_ready_reassert", 32'(in_ready[1]), 32'h1);
    for (int j = 1; j <= 4; j++) begin
      chk("drain_a", 32'({out_valid, out_src, out_data}), 32'({1'b1, 3'd1, 8'(j)}));
      tick;
    end
    chk("drain_a_idle", 32'(out_valid), 32'h0);
    out_ready = 1'b0;
    for (int j = 5; j <= 8; j++) begin
      in_data[15:8] = 8'(j);
      in_valid = 5'b00010;
      tick;
    end
    in_valid = '0;
    chk("wrap_lvl1", 32'(lv(1)), 32'd3);
    out_ready = 1'b1;
    for (int j = 5; j <= 8; j++) begin
      chk("drain_b", 32'({out_valid, out_src, out_data}), 32'({1'b1, 3'd1, 8'(j)}));
      tick;
    end
    chk("drain_b_idle", 32'(out_valid), 32'h0);

    // random stall with scoreboard and starvation bound
    pv = out_valid;
    pr = out_ready;
    pd = out_data;
    ps = out_src;
    for (int i = 0; i < NC; i++) begin
      pl[i] = lv(i);
      st[i] = 0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (pv && !pr)
        chk("stall_hold", 32'({out_valid, out_src, out_data}), 32'({1'b1, ps, pd}));
      if (out_valid && (!pv || pr)) begin
        for (int i = 0; i < NC; i++) begin
          if (3'(i) == out_src) st[i] = 0;
          else if (pl[i] != '0) begin
            st[i]++;
            chk("starve_bound", 32'(st[i] <= NC - 1), 32'h1);
          end else st[i] = 0;
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) sb_pop();
      in_valid = (cyc < 1000) ? 5'($urandom) : (5'($urandom) & 5'($urandom) & 5'($urandom));
      in_data = 40'({$urandom, $urandom});
      for (int i = 0; i < NC; i++)
        if (in_valid[i] && in_ready[i]) sbq.push_back({4'(i), in_data[i*8 +: 8]});
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      ps = out_src;
      for (int i = 0; i < NC; i++) pl[i] = lv(i);
      tick;
    end
    in_valid = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) sb_pop();
      tick;
    end
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    chk("stall_drain_idle", 32'(out_valid), 32'h0);

    // reset mid-stream
    out_ready = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NC; i++) in_data[i*8 +: 8] = {4'(i), 4'(p)};
      in_valid = 5'b10110;
      tick;
    end
    in_valid = '0;
    chk("mid_pre_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    tick;
    chk("mid_lvl", 32'(lvl), 32'h0);
    chk("mid_out", 32'({out_valid, out_src, out_data}), 32'h0);
    rst_n = 1'b1;
    in_data[2*8 +: 8] = 8'h2A;
    in_data[4*8 +: 8] = 8'h4B;
    in_valid = 5'b10100;
    tick;
    in_valid = '0;
    out_ready = 1'b1;
    tick;
    chk("mid_first_grant", 32'({out_valid, out_src, out_data}), 32'({1'b1, 3'd2, 8'h2A}));
    chk("mid_lvl4", 32'(lv(4)), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
